// File: rtl/sector_serializer.sv
// sector_serializer: serialises one 512-byte sector from a cache read port as
// a gated, MSB-first bit stream: preamble zeros, sync byte, data, optional CRC.
// Build option: define SECTOR_CRC_EN to append a 16-bit CRC-CCITT field
// (poly 0x1021, init 0xFFFF) computed over the 512 data bytes.
// Bit cells advance only on bit_tick. Each state names the phase of the bit
// that the next tick will drive.
module sector_serializer #(
  parameter int          PREAMBLE_BITS = 32,
  parameter logic [7:0]  SYNC_BYTE     = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       bit_tick,
  output logic [8:0] mem_addr,
  input  logic [7:0] mem_dout,
  output logic       ser_data,
  output logic       ser_gate,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SYNC = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
`ifdef SECTOR_CRC_EN
  localparam logic [2:0] S_CRC  = 3'd4;
`endif
  localparam logic [2:0] S_FIN  = 3'd5;

  localparam logic [12:0] PRE_LAST  = 13'(PREAMBLE_BITS - 1);
  // A value of 4096 in DATA means every data bit has already been driven.
  localparam logic [12:0] DATA_BITS = 13'd4096;
  localparam logic [8:0]  ADDR_LAST = 9'd511;

  logic [2:0]  state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [8:0]  addr_q, addr_d;
  logic        ser_data_q, ser_data_d;
  logic        ser_gate_q, ser_gate_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        go_fin;

`ifdef SECTOR_CRC_EN
  localparam logic [12:0] CRC_BITS = 13'd16;
  logic [15:0] crc_q, crc_d;

  // One CRC-CCITT byte step, MSB of the data byte first.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction
`endif

  // Next-state logic: frame sequencing, shift register, prefetch address.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    addr_d     = addr_q;
    ser_data_d = ser_data_q;
    ser_gate_d = ser_gate_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    go_fin     = 1'b0;
`ifdef SECTOR_CRC_EN
    crc_d      = crc_q;
`endif
    case (state_q)
      S_IDLE: begin
        addr_d     = '0;
        cnt_d      = '0;
        ser_data_d = 1'b0;
        ser_gate_d = 1'b0;
        if (start) begin
          state_d = S_PRE;
          busy_d  = 1'b1;
`ifdef SECTOR_CRC_EN
          crc_d   = 16'hFFFF;
`endif
        end
      end
      S_PRE: begin
        if (bit_tick) begin
          ser_gate_d = 1'b1;
          ser_data_d = 1'b0;
          if (cnt_q == PRE_LAST) begin
            state_d = S_SYNC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 13'd1;
          end
        end
      end
      S_SYNC: begin
        if (bit_tick) begin
          ser_gate_d = 1'b1;
          // ~cnt selects bit 7-cnt: MSB first.
          ser_data_d = SYNC_BYTE[~cnt_q[2:0]];
          if (cnt_q[2:0] == 3'd7) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 13'd1;
          end
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          if (cnt_q == DATA_BITS) begin
`ifdef SECTOR_CRC_EN
            ser_gate_d = 1'b1;
            ser_data_d = crc_q[15];
            crc_d      = {crc_q[14:0], 1'b0};
            state_d    = S_CRC;
            cnt_d      = 13'd1;
`else
            go_fin = 1'b1;
`endif
          end else begin
            ser_gate_d = 1'b1;
            cnt_d      = cnt_q + 13'd1;
            if (cnt_q[2:0] == 3'd0) begin
              // Byte boundary: load the prefetched byte and fetch the next.
              ser_data_d = mem_dout[7];
              shreg_d    = {mem_dout[6:0], 1'b0};
              if (addr_q != ADDR_LAST) addr_d = addr_q + 9'd1;
`ifdef SECTOR_CRC_EN
              crc_d      = crc_byte(crc_q, mem_dout);
`endif
            end else begin
              ser_data_d = shreg_q[7];
              shreg_d    = {shreg_q[6:0], 1'b0};
            end
          end
        end
      end
`ifdef SECTOR_CRC_EN
      S_CRC: begin
        if (bit_tick) begin
          if (cnt_q == CRC_BITS) begin
            go_fin = 1'b1;
          end else begin
            ser_data_d = crc_q[15];
            crc_d      = {crc_q[14:0], 1'b0};
            cnt_d      = cnt_q + 13'd1;
          end
        end
      end
`endif
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Tick after the last frame bit: drop the gate and pulse done.
    if (go_fin) begin
      state_d    = S_FIN;
      ser_gate_d = 1'b0;
      ser_data_d = 1'b0;
      done_d     = 1'b1;
      busy_d     = 1'b0;
      addr_d     = '0;
      cnt_d      = '0;
    end
  end

  // State registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      addr_q     <= '0;
      ser_data_q <= 1'b0;
      ser_gate_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      addr_q     <= addr_d;
      ser_data_q <= ser_data_d;
      ser_gate_q <= ser_gate_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef SECTOR_CRC_EN
  // Running CRC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end
`endif

  assign mem_addr = addr_q;
  assign ser_data = ser_data_q;
  assign ser_gate = ser_gate_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
